// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bus between the 5-stage datapath and the hazard control unit.
// The datapath (master) supplies ID/EX stage information; the control unit
// (slave) returns the pipeline-register controls, the halted flag and the
// event counters.
interface pipeline_hazard_ctrl_if #(
    parameter int RegAddrBits = 3,
    parameter int CntWidth    = 16
);
    logic [RegAddrBits-1:0] id_rs;
    logic [RegAddrBits-1:0] id_rt;
    logic                   id_uses_rs;
    logic                   id_uses_rt;
    logic                   id_is_halt;
    logic                   ex_mem_read;
    logic                   ex_reg_write;
    logic [RegAddrBits-1:0] ex_rd;
    logic                   ex_branch_taken;
    logic                   pc_write;
    logic                   ifid_write;
    logic                   ifid_flush;
    logic                   idex_bubble;
    logic                   halted;
    logic [CntWidth-1:0]    stall_cnt;
    logic [CntWidth-1:0]    flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_halt,
               ex_mem_read, ex_reg_write, ex_rd, ex_branch_taken,
        input  pc_write, ifid_write, ifid_flush, idex_bubble,
               halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_halt,
               ex_mem_read, ex_reg_write, ex_rd, ex_branch_taken,
        output pc_write, ifid_write, ifid_flush, idex_bubble,
               halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard control for the 16-bit, 8-register, 5-stage processor.
// Stalls the front end on load-use hazards, flushes wrong-path work on a
// taken branch, drains and freezes the pipeline on HALT, and keeps
// saturating stall/flush event counters. Control outputs are combinational
// from state and inputs; state, drain count, halted and counters are flops.
module pipeline_hazard_ctrl #(
    parameter int RegAddrBits = 3,
    parameter int CntWidth    = 16,
    parameter int DrainCycles = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    pipeline_hazard_ctrl_if.slave  bus
);
    localparam int DrainBits = $clog2(DrainCycles + 1);
    localparam logic [DrainBits-1:0] DrainLast = DrainBits'(DrainCycles - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [DrainBits-1:0]   drain_r;
    logic [DrainBits-1:0]   drain_nxt_s;
    logic                   halted_r;
    logic [CntWidth-1:0]    stall_cnt_r;
    logic [CntWidth-1:0]    flush_cnt_r;
    logic                   stall_inc_s;
    logic                   flush_inc_s;
    logic                   lu_s;
    logic                   pc_write_s;
    logic                   ifid_write_s;
    logic                   ifid_flush_s;
    logic                   idex_bubble_s;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CntWidth'(1);
        end
    endfunction

    // Load-use hazard: the load in EX writes a register the ID instruction reads ($0 excluded).
    always_comb begin
        lu_s = bus.ex_mem_read && bus.ex_reg_write &&
               (bus.ex_rd != {RegAddrBits{1'b0}}) &&
               ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));
    end

    // Next-state, event strobes and pipeline-register controls.
    always_comb begin
        state_nxt_s   = state_r;
        drain_nxt_s   = drain_r;
        stall_inc_s   = 1'b0;
        flush_inc_s   = 1'b0;
        pc_write_s    = 1'b0;
        ifid_write_s  = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b1;
        if (RST) begin
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (bus.ex_branch_taken) begin
                        // Wrong-path flush wins; any HALT in ID is discarded.
                        pc_write_s    = 1'b1;
                        ifid_write_s  = 1'b1;
                        ifid_flush_s  = 1'b1;
                        idex_bubble_s = 1'b1;
                        flush_inc_s   = 1'b1;
                    end else if (lu_s) begin
                        // Hold PC and IF/ID; a HALT in ID waits here too.
                        idex_bubble_s = 1'b1;
                        stall_inc_s   = 1'b1;
                    end else if (bus.id_is_halt) begin
                        // HALT proceeds into EX; the front end stops fetching.
                        idex_bubble_s = 1'b0;
                        state_nxt_s   = ST_DRAIN;
                        drain_nxt_s   = {DrainBits{1'b0}};
                    end else begin
                        pc_write_s    = 1'b1;
                        ifid_write_s  = 1'b1;
                        idex_bubble_s = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_r == DrainLast) begin
                        state_nxt_s = ST_HALTED;
                    end else begin
                        drain_nxt_s = drain_r + DrainBits'(1);
                    end
                end
                ST_HALTED: begin
                    state_nxt_s = ST_HALTED;
                end
                default: begin
                    state_nxt_s = ST_RUN;
                    drain_nxt_s = {DrainBits{1'b0}};
                end
            endcase
        end
    end

    // State, drain count, halted flag and saturating event counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= ST_RUN;
            drain_r     <= {DrainBits{1'b0}};
            halted_r    <= 1'b0;
            stall_cnt_r <= {CntWidth{1'b0}};
            flush_cnt_r <= {CntWidth{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            drain_r  <= drain_nxt_s;
            halted_r <= (state_nxt_s == ST_HALTED);
            if (stall_inc_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (flush_inc_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
        end
    end

    assign bus.pc_write    = pc_write_s;
    assign bus.ifid_write  = ifid_write_s;
    assign bus.ifid_flush  = ifid_flush_s;
    assign bus.idex_bubble = idex_bubble_s;
    assign bus.halted      = halted_r;
    assign bus.stall_cnt   = stall_cnt_r;
    assign bus.flush_cnt   = flush_cnt_r;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Two instances share stimulus:
// a default one (CntWidth=16) and a narrow one (CntWidth=2) for saturation.
// Expected registered values are queued when stimulus is applied and
// compared after the clock edge.
module tb_pipeline_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] id_rs = 3'd0;
    logic [2:0] id_rt = 3'd0;
    logic       id_uses_rs = 1'b0;
    logic       id_uses_rt = 1'b0;
    logic       id_is_halt = 1'b0;
    logic       ex_mem_read = 1'b0;
    logic       ex_reg_write = 1'b0;
    logic [2:0] ex_rd = 3'd0;
    logic       ex_branch_taken = 1'b0;

    int checks = 0;
    int failures = 0;

    // bench reference model: 0=RUN 1=DRAIN 2=HALTED
    int m_state = 0;
    int m_drain = 0;
    int m_halted = 0;
    int m_stall = 0;
    int m_flush = 0;
    int m_stall2 = 0;
    int m_flush2 = 0;

    typedef struct {
        string tag;
        int    halted;
        int    stall;
        int    flush;
        int    stall2;
        int    flush2;
    } exp_t;
    exp_t sb_q[$];

    pipeline_hazard_ctrl_if #(.RegAddrBits(3), .CntWidth(16)) bus_a ();
    pipeline_hazard_ctrl_if #(.RegAddrBits(3), .CntWidth(2))  bus_b ();

    pipeline_hazard_ctrl #(.RegAddrBits(3), .CntWidth(16), .DrainCycles(3)) u_dut (
        .CLK(clk), .RST(rst), .bus(bus_a)
    );
    pipeline_hazard_ctrl #(.RegAddrBits(3), .CntWidth(2), .DrainCycles(3)) u_dut_sat (
        .CLK(clk), .RST(rst), .bus(bus_b)
    );

    assign bus_a.id_rs = id_rs;            assign bus_b.id_rs = id_rs;
    assign bus_a.id_rt = id_rt;            assign bus_b.id_rt = id_rt;
    assign bus_a.id_uses_rs = id_uses_rs;  assign bus_b.id_uses_rs = id_uses_rs;
    assign bus_a.id_uses_rt = id_uses_rt;  assign bus_b.id_uses_rt = id_uses_rt;
    assign bus_a.id_is_halt = id_is_halt;  assign bus_b.id_is_halt = id_is_halt;
    assign bus_a.ex_mem_read = ex_mem_read;   assign bus_b.ex_mem_read = ex_mem_read;
    assign bus_a.ex_reg_write = ex_reg_write; assign bus_b.ex_reg_write = ex_reg_write;
    assign bus_a.ex_rd = ex_rd;            assign bus_b.ex_rd = ex_rd;
    assign bus_a.ex_branch_taken = ex_branch_taken;
    assign bus_b.ex_branch_taken = ex_branch_taken;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int rs, input int rt, input bit urs, input bit urt,
                          input bit halt, input bit mr, input bit rw, input int rd,
                          input bit br);
        id_rs = 3'(rs); id_rt = 3'(rt);
        id_uses_rs = urs; id_uses_rt = urt; id_is_halt = halt;
        ex_mem_read = mr; ex_reg_write = rw; ex_rd = 3'(rd);
        ex_branch_taken = br;
    endtask

    function automatic bit model_lu();
        return ex_mem_read && ex_reg_write && (ex_rd != 3'd0) &&
               ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    endfunction

    task automatic model_reset();
        m_state = 0; m_drain = 0; m_halted = 0;
        m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
    endtask

    task automatic check_comb(input string tag);
        int pw, iw, ifl, bub;
        if (rst) begin
            pw = 0; iw = 0; ifl = 1; bub = 1;
        end else if (m_state != 0) begin
            pw = 0; iw = 0; ifl = 0; bub = 1;
        end else if (ex_branch_taken) begin
            pw = 1; iw = 1; ifl = 1; bub = 1;
        end else if (model_lu()) begin
            pw = 0; iw = 0; ifl = 0; bub = 1;
        end else if (id_is_halt) begin
            pw = 0; iw = 0; ifl = 0; bub = 0;
        end else begin
            pw = 1; iw = 1; ifl = 0; bub = 0;
        end
        chk({tag, ".pc_write"},    32'(bus_a.pc_write),    32'(pw));
        chk({tag, ".ifid_write"},  32'(bus_a.ifid_write),  32'(iw));
        chk({tag, ".ifid_flush"},  32'(bus_a.ifid_flush),  32'(ifl));
        chk({tag, ".idex_bubble"}, 32'(bus_a.idex_bubble), 32'(bub));
    endtask

    // Apply the already-set inputs for one cycle and check both phases.
    task automatic step(input string tag);
        exp_t e;
        #1;
        check_comb(tag);
        if (m_state == 0) begin
            if (ex_branch_taken) begin
                if (m_flush < 65535) m_flush++;
                if (m_flush2 < 3) m_flush2++;
            end else if (model_lu()) begin
                if (m_stall < 65535) m_stall++;
                if (m_stall2 < 3) m_stall2++;
            end else if (id_is_halt) begin
                m_state = 1; m_drain = 0;
            end
        end else if (m_state == 1) begin
            if (m_drain == 2) begin
                m_state = 2; m_halted = 1;
            end else begin
                m_drain++;
            end
        end
        e.tag = tag; e.halted = m_halted; e.stall = m_stall; e.flush = m_flush;
        e.stall2 = m_stall2; e.flush2 = m_flush2;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({e.tag, ".halted"},    32'(bus_a.halted),    32'(e.halted));
        chk({e.tag, ".stall_cnt"}, 32'(bus_a.stall_cnt), 32'(e.stall));
        chk({e.tag, ".flush_cnt"}, 32'(bus_a.flush_cnt), 32'(e.flush));
        chk({e.tag, ".stall_sat"}, 32'(bus_b.stall_cnt), 32'(e.stall2));
        chk({e.tag, ".flush_sat"}, 32'(bus_b.flush_cnt), 32'(e.flush2));
        @(negedge clk);
    endtask

    initial begin
        int sat_exp[5];
        sat_exp = '{1, 2, 3, 3, 3};

        // reset state
        @(negedge clk); @(negedge clk);
        model_reset();
        check_comb("reset");
        chk("reset.halted", 32'(bus_a.halted), 32'd0);
        chk("reset.stall_cnt", 32'(bus_a.stall_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        step("idle");

        // branch + HALT + load-use in one cycle: flush wins, stays RUN
        set_in(3, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3, 1'b1);
        step("br_halt_lu");
        chk("br_halt_lu.flush1", 32'(bus_a.flush_cnt), 32'd1);
        chk("br_halt_lu.stall0", 32'(bus_a.stall_cnt), 32'd0);
        set_in(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step("after_flush_run");

        // load-use on rs and on rt
        set_in(3, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b0);
        step("lu_rs");
        chk("lu_rs.stall1", 32'(bus_a.stall_cnt), 32'd1);
        set_in(1, 5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5, 1'b0);
        step("lu_rt");

        // no false stalls
        set_in(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        step("no_lu_r0");
        set_in(3, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b0);
        step("no_lu_unused");
        set_in(3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
        step("no_lu_noload");
        set_in(4, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b0);
        step("no_lu_diffreg");

        // HALT held during a load-use stall, then accepted
        set_in(3, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3, 1'b0);
        step("halt_held_lu");
        set_in(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        step("halt_accept");
        set_in(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        step("drain1_br");
        chk("drain1.halted0", 32'(bus_a.halted), 32'd0);
        set_in(3, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b0);
        step("drain2_lu");
        chk("drain2.halted0", 32'(bus_a.halted), 32'd0);
        set_in(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        step("drain3_br");
        chk("drain3.halted1", 32'(bus_a.halted), 32'd1);
        step("halted_br");
        set_in(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step("halted_idle");

        // reset mid-DRAIN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        set_in(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        step("halt_accept2");
        set_in(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        step("pre_rst_flush_ignored");
        rst = 1'b1;
        #1;
        model_reset();
        check_comb("rst_mid_drain");
        chk("rst_mid_drain.halted", 32'(bus_a.halted), 32'd0);
        chk("rst_mid_drain.stall_cnt", 32'(bus_a.stall_cnt), 32'd0);
        chk("rst_mid_drain.flush_cnt", 32'(bus_a.flush_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step("post_rst_run");
        step("post_rst_run2");

        // saturation on the narrow counter instance
        set_in(2, 6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("sat%0d", i));
            chk($sformatf("sat%0d.narrow", i), 32'(bus_b.stall_cnt), 32'(sat_exp[i]));
        end
        set_in(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step("final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
